// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer on the reference clock: timed PLL reset, lock wait with
// timeout, lock stability filter, automatic retry and a sticky fault after too many failures.
module pll_reset_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILTER  = 1024,
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int MAX_RETRIES  = 8
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  localparam int TMR_MAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES - 1 : LOCK_TIMEOUT - 1;
  localparam int TW      = $clog2(TMR_MAX) + 1;
  localparam int FW      = $clog2(LOCK_FILTER - 1) + 1;

  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [3:0]    retry_q, retry_d;
  logic          sync1_q, lockedS_q;
  logic          pllRst_q, pllRst_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic          failAttempt;
  logic [3:0]    retryInc;

  assign retryInc = (retry_q == 4'd15) ? 4'd15 : retry_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    filt_d      = filt_q;
    retry_d     = retry_q;
    failAttempt = 1'b0;

    case (state_q)
      S_RESET_PLL: begin
        if (timer_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lockedS_q) begin
          state_d = S_FILTER;
          timer_d = '0;
          filt_d  = '0;
        end else if (timer_q == LOCK_LAST) begin
          failAttempt = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_FILTER: begin
        // A dropout during filtering just restarts the lock wait; it is not a failure.
        if (!lockedS_q) begin
          state_d = S_WAIT_LOCK;
          timer_d = '0;
          filt_d  = '0;
        end else if (filt_q == FILT_LAST) begin
          state_d = S_RUN;
          filt_d  = '0;
        end else begin
          filt_d = filt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lockedS_q) failAttempt = 1'b1;
      end
      S_FAULT: ;
      default: begin
        state_d = S_RESET_PLL;
        timer_d = '0;
        filt_d  = '0;
      end
    endcase

    if (failAttempt) begin
      retry_d = retryInc;
      timer_d = '0;
      filt_d  = '0;
      state_d = (retryInc >= RETRY_LIM) ? S_FAULT : S_RESET_PLL;
    end

    if (restart) begin
      state_d = S_RESET_PLL;
      timer_d = '0;
      filt_d  = '0;
      retry_d = '0;
    end

    // Outputs follow the next state so they change on the same edge as the state.
    pllRst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
    ready_d  = (state_d == S_RUN);
    fault_d  = (state_d == S_FAULT);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET_PLL;
      timer_q   <= '0;
      filt_q    <= '0;
      retry_q   <= '0;
      sync1_q   <= 1'b0;
      lockedS_q <= 1'b0;
      pllRst_q  <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      filt_q    <= filt_d;
      retry_q   <= retry_d;
      sync1_q   <= pll_locked;
      lockedS_q <= sync1_q;
      pllRst_q  <= pllRst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst     = pllRst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters
// (RST_CYCLES=16, LOCK_FILTER=8, LOCK_TIMEOUT=100, MAX_RETRIES=8).
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [2:0] state;

  int testsRun    = 0;
  int testsFailed = 0;

  pll_reset_sequencer #(
    .RST_CYCLES  (16),
    .LOCK_FILTER (8),
    .LOCK_TIMEOUT(100),
    .MAX_RETRIES (8)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count),
    .state      (state)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive inputs just after an edge, then advance the given number of rising edges
  // and land 1ns past the last one, where outputs are sampled.
  task automatic applyStimulus(input logic lockedIn, input logic restartIn, input int cycles);
    pll_locked = lockedIn;
    restart    = restartIn;
    repeat (cycles) begin
      @(posedge refclk);
      #1;
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_state", state, 0);
    checkOutput("rst_pll_rst", pll_rst, 1);
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_retry", retry_count, 0);
    applyStimulus(0, 0, 3);
    checkOutput("rst_hold_pll_rst", pll_rst, 1);
    rst_n = 1'b1;

    // Normal bring-up: 16 cycles of PLL reset, lock raised 40 cycles after release.
    applyStimulus(0, 0, 15);
    checkOutput("s1_rst_r15", pll_rst, 1);
    applyStimulus(0, 0, 1);
    checkOutput("s1_rst_r16", pll_rst, 0);
    checkOutput("s1_wait_state", state, 1);
    applyStimulus(0, 0, 24);
    applyStimulus(1, 0, 2);
    checkOutput("s1_state_e2", state, 1);
    applyStimulus(1, 0, 1);
    checkOutput("s1_state_e3", state, 2);
    applyStimulus(1, 0, 7);
    checkOutput("s1_ready_e10", ready, 0);
    applyStimulus(1, 0, 1);
    checkOutput("s1_ready_e11", ready, 1);
    checkOutput("s1_state_e11", state, 3);
    checkOutput("s1_retry", retry_count, 0);
    checkOutput("s1_pll_rst", pll_rst, 0);

    // One-cycle lock loss in RUN.
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    checkOutput("s4_ready_d2", ready, 1);
    applyStimulus(1, 0, 1);
    checkOutput("s4_ready_d3", ready, 0);
    checkOutput("s4_pll_rst_d3", pll_rst, 1);
    checkOutput("s4_retry_d3", retry_count, 1);
    checkOutput("s4_state_d3", state, 0);
    applyStimulus(1, 0, 15);
    checkOutput("s4_pll_rst_d18", pll_rst, 1);
    applyStimulus(1, 0, 1);
    checkOutput("s4_pll_rst_d19", pll_rst, 0);
    checkOutput("s4_state_d19", state, 1);
    applyStimulus(1, 0, 8);
    checkOutput("s4_ready_d27", ready, 0);
    checkOutput("s4_state_d27", state, 2);
    applyStimulus(1, 0, 1);
    checkOutput("s4_ready_d28", ready, 1);
    checkOutput("s4_retry_d28", retry_count, 1);

    // Restart pulse while running.
    applyStimulus(1, 1, 1);
    checkOutput("s5r_state", state, 0);
    checkOutput("s5r_pll_rst", pll_rst, 1);
    checkOutput("s5r_ready", ready, 0);
    checkOutput("s5r_retry", retry_count, 0);
    checkOutput("s5r_fault", fault, 0);
    applyStimulus(1, 0, 15);
    checkOutput("s5r_pll_rst_x16", pll_rst, 1);
    applyStimulus(1, 0, 1);
    checkOutput("s5r_state_x17", state, 1);
    applyStimulus(1, 0, 4);
    checkOutput("s5r_state_x21", state, 2);

    // Three-cycle dropout while filtering (synchronized count reaches 5 first).
    applyStimulus(0, 0, 2);
    checkOutput("s2_state_g2", state, 2);
    applyStimulus(0, 0, 1);
    checkOutput("s2_state_g3", state, 1);
    checkOutput("s2_ready_g3", ready, 0);
    applyStimulus(1, 0, 2);
    checkOutput("s2_state_g5", state, 1);
    applyStimulus(1, 0, 1);
    checkOutput("s2_state_g6", state, 2);
    applyStimulus(1, 0, 7);
    checkOutput("s2_ready_g13", ready, 0);
    applyStimulus(1, 0, 1);
    checkOutput("s2_ready_g14", ready, 1);
    checkOutput("s2_retry_g14", retry_count, 0);

    // Lock never arrives: retry every 116 cycles until the fault latches.
    applyStimulus(0, 1, 1);
    checkOutput("s3_state_y1", state, 0);
    checkOutput("s3_retry_y1", retry_count, 0);
    applyStimulus(0, 0, 15);
    checkOutput("s3_pll_rst_y16", pll_rst, 1);
    applyStimulus(0, 0, 1);
    checkOutput("s3_pll_rst_y17", pll_rst, 0);
    applyStimulus(0, 0, 99);
    checkOutput("s3_pll_rst_y116", pll_rst, 0);
    checkOutput("s3_retry_y116", retry_count, 0);
    applyStimulus(0, 0, 1);
    checkOutput("s3_pll_rst_y117", pll_rst, 1);
    checkOutput("s3_retry_y117", retry_count, 1);
    checkOutput("s3_state_y117", state, 0);
    for (int k = 2; k <= 8; k++) begin
      applyStimulus(0, 0, 115);
      checkOutput("s3_retry_before", retry_count, k - 1);
      checkOutput("s3_pll_rst_before", pll_rst, 0);
      applyStimulus(0, 0, 1);
      checkOutput("s3_retry_after", retry_count, k);
      checkOutput("s3_pll_rst_after", pll_rst, 1);
      checkOutput("s3_state_after", state, (k == 8) ? 4 : 0);
      checkOutput("s3_fault_after", fault, (k == 8) ? 1 : 0);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 100);
      checkOutput("s3_hold_state", state, 4);
      checkOutput("s3_hold_fault", fault, 1);
      checkOutput("s3_hold_pll_rst", pll_rst, 1);
      checkOutput("s3_hold_ready", ready, 0);
    end

    // Restart pulse out of FAULT, followed by a normal sequence.
    applyStimulus(1, 1, 1);
    checkOutput("s5f_state", state, 0);
    checkOutput("s5f_fault", fault, 0);
    checkOutput("s5f_retry", retry_count, 0);
    checkOutput("s5f_pll_rst", pll_rst, 1);
    checkOutput("s5f_ready", ready, 0);
    applyStimulus(1, 0, 15);
    checkOutput("s5f_pll_rst_z16", pll_rst, 1);
    applyStimulus(1, 0, 1);
    checkOutput("s5f_state_z17", state, 1);
    applyStimulus(1, 0, 8);
    checkOutput("s5f_ready_z25", ready, 0);
    applyStimulus(1, 0, 1);
    checkOutput("s5f_ready_z26", ready, 1);

    // Asynchronous reset between edges while filtering.
    applyStimulus(1, 1, 1);
    applyStimulus(1, 0, 20);
    checkOutput("s6_state_w21", state, 2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s6_async_pll_rst", pll_rst, 1);
    checkOutput("s6_async_ready", ready, 0);
    checkOutput("s6_async_state", state, 0);
    checkOutput("s6_async_retry", retry_count, 0);
    applyStimulus(1, 0, 2);
    checkOutput("s6_held_state", state, 0);
    rst_n = 1'b1;
    applyStimulus(1, 0, 15);
    checkOutput("s6_pll_rst_r15", pll_rst, 1);
    applyStimulus(1, 0, 1);
    checkOutput("s6_pll_rst_r16", pll_rst, 0);
    checkOutput("s6_state_r16", state, 1);
    applyStimulus(1, 0, 8);
    checkOutput("s6_ready_r24", ready, 0);
    checkOutput("s6_state_r24", state, 2);
    applyStimulus(1, 0, 1);
    checkOutput("s6_ready_r25", ready, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Sequences the 4-output video/system PLL from power-up to a qualified locked state. Holds the PLL in reset for a minimum time, then waits for `locked` with a timeout. It filters `locked` for stability before asserting `ready`, which gates the downstream clock-domain reset releases. It also recovers automatically from lock loss or lock timeout, up to a retry limit, then latches a fault. It runs on the PLL reference clock (74.25 MHz), because the PLL outputs are not trustworthy before lock.

Parameters:
RST_CYCLES, 16, refclk cycles pll_rst is held high per reset attempt (≥1)
LOCK_FILTER, 1024, consecutive synchronized-lock cycles required before ready (≥1)
LOCK_TIMEOUT, 1048576, refclk cycles allowed in WAIT_LOCK before a retry (≥1)
MAX_RETRIES, 8, failed attempts (timeouts + lock losses) before FAULT (1..15)

Ports:
refclk  input  1  PLL reference clock; sole clock of the block
rst_n  input  1  asynchronous active-low reset
pll_locked  input  1  PLL locked output, asynchronous to refclk
restart  input  1  synchronous one-cycle pulse; forces a full re-sequence and clears fault/retries
pll_rst  output  1  drives the PLL rst input, active-high
ready  output  1  PLL qualified locked; downstream domains may leave reset
fault  output  1  sticky; retry limit reached, PLL held in reset
retry_count  output  4  failed attempts since reset/restart, saturating at 15
state  output  3  current state encoding, for debug

Behaviour:
- Reset (rst_n=0, async): state=RESET_PLL, pll_rst=1, ready=0, fault=0, retry_count=0, all timers=0, sync flops=0.
- pll_locked passes through a 2-flop synchronizer; locked_s is the second flop. Every decision uses only locked_s.
- All outputs are registered. The state encodings are RESET_PLL=0, WAIT_LOCK=1, FILTER=2, RUN=3, FAULT=4.
- RESET_PLL:
  - pll_rst=1, ready=0.
  - The timer counts 0..RST_CYCLES-1; on the terminal count, go to WAIT_LOCK and clear the timer.
  - pll_rst is high for exactly RST_CYCLES cycles per entry.
- WAIT_LOCK:
  - pll_rst=0. The timer increments every cycle.
  - If locked_s=1, go to FILTER with the filter counter at 0.
  - Else, if the timer reaches LOCK_TIMEOUT-1, count a failed attempt (see below).
  - If both conditions hold in the same cycle, lock wins.
- FILTER:
  - pll_rst=0, and the filter counter increments while locked_s=1.
  - If locked_s=0, return to WAIT_LOCK with the timer cleared. This is not a failed attempt.
  - When the counter reaches LOCK_FILTER-1 with locked_s=1, go to RUN.
- RUN:
  - pll_rst=0, ready=1.
  - If locked_s=0, count a failed attempt; ready is 0 from the same edge that leaves RUN.
- Failed attempt:
  - retry_count increments, saturating at 15.
  - If the new value is ≥ MAX_RETRIES, go to FAULT. Otherwise, go to RESET_PLL with the timer cleared.
- FAULT: pll_rst=1, ready=0, fault=1. The block stays here until restart or rst_n.
- restart=1 has the highest priority in any state:
  - Next state is RESET_PLL; timers, retry_count and fault are all cleared.
  - restart held high keeps re-entering RESET_PLL, extending pll_rst until one cycle after it falls, plus RST_CYCLES.
- Latency: ready rises exactly LOCK_FILTER+3 refclk edges after the first edge that samples pll_locked=1, given no dropouts.
- Counter widths: $clog2 of the largest terminal value plus 1. No counter may wrap: each is cleared on state exit and never counts past its terminal value.
- Async reset asserted mid-operation immediately forces the reset values, including pll_rst=1 and ready=0, with no clock needed.

Test Plan:
1. Normal bring-up, RST_CYCLES=16, LOCK_FILTER=8: release rst_n, then raise pll_locked 40 cycles later → pll_rst high for exactly 16 cycles after rst_n release; ready=1 exactly 11 edges after pll_locked sampled high; retry_count=0.
2. Lock glitch during FILTER: pll_locked low for 3 cycles at filter count 5 → returns to WAIT_LOCK, then FILTER again; ready rises 11 edges after lock returns; retry_count stays 0.
3. Timeout, LOCK_TIMEOUT=100, pll_locked held 0: → pll_rst re-asserts every 16+100 cycles; retry_count steps 1, 2, …; at 8 → fault=1, pll_rst=1, state=4, stable for 1000 cycles.
4. Lock loss in RUN: drop pll_locked for 1 cycle → ready=0 on the 3rd edge after the drop; pll_rst high for 16 cycles; retry_count=1; re-lock → ready again.
5. restart pulse in FAULT and in RUN → fault=0, retry_count=0, ready=0, pll_rst=1 on the next edge, then normal sequence as in scenario 1.
6. rst_n asserted between clock edges mid-FILTER → pll_rst=1, ready=0, retry_count=0 immediately; after release, the full sequence restarts.
